clk_div_multi: RTL and testbench
================================

# clk_div_multi

Parametrised multi-channel clock divider for the watch datapath. From the single 50 MHz board clock it produces N_CH independent divided outputs (1 kHz scan, 1 Hz seconds, 2 Hz blink, …). Each channel has a runtime-reloadable divisor, its own enable, and a square-wave or single-cycle-tick mode. A global sync clear phase-aligns all channels. It replaces the fixed single-ratio dividers feeding the timekeeping and display blocks.

## Interface
- CLK_HZ, 50_000_000, input clock frequency; documentation only, not used in logic
- CNT_W, 32, counter and divisor width
- N_CH, 4, number of channels; 1..8
- DIV_INIT, {25_000, 25_000_000, 12_500_000, 250_000} packed N_CH×CNT_W with ch0 in the LSBs, reset divisor per channel
- CLOCK  in  1  system clock; all logic on the rising edge
- RESET  in  1  asynchronous, active-high reset
- en  in  N_CH  per-channel count enable
- mode  in  N_CH  per channel: 0 = square (toggle), 1 = tick (one-cycle pulse)
- load  in  1  one-cycle strobe to reload a divisor
- load_ch  in  clog2(N_CH) (min 1)  target channel of load
- load_div  in  CNT_W  new divisor value
- sync_clr  in  1  restart all channel counters in phase
- clk_out  out  N_CH  divided output per channel
- wrap  out  N_CH  one-cycle strobe at each channel's count wrap, independent of mode

## Operation
- Per channel: counter cnt, active divisor div, pending divisor pdiv plus pend flag.
- Effective divisor D = max(div, 1); a divisor of 0 is treated as 1.
- Channel enabled: if cnt == D-1, cnt←0 and wrap event; otherwise cnt←cnt+1.
- Square mode: clk_out toggles on each wrap, giving f = CLOCK/(2D). Tick mode: clk_out = 1 for exactly the wrap cycle, giving f = CLOCK/D.
- D=1: square toggles every cycle (CLOCK/2); tick output is constantly 1 while enabled.
- Channel disabled: cnt holds, wrap = 0, square clk_out holds its level, tick clk_out = 0.
- Divisor load, glitch-free:
  - Channel enabled: load_div goes to pdiv and pend←1; it is applied (div←pdiv, pend←0) at the next wrap.
  - Load in the same cycle as a wrap: applied at that wrap directly.
  - Second load while pending: overwrites pdiv.
  - Channel disabled: applied immediately; cnt←0.
- load_ch ≥ N_CH: load ignored.
- Switching mode mid-run: takes effect next cycle; cnt is unaffected.
- sync_clr (all channels, same edge): cnt←0, square clk_out←0, wrap←0, and any pending divisor is applied. A load in the same cycle is applied directly.
- Priority: RESET > sync_clr > load/count.

## Timing
- Reset values: cnt=0, clk_out=0, wrap=0, div=DIV_INIT[ch], pend=0.
- Outputs are registered. wrap and the clk_out change appear in the cycle after the edge where cnt==D-1 was sampled.
- After en rises, or after RESET/sync_clr release with en high: the first wrap is asserted D cycles later; the period is then exactly D cycles.
- A new divisor affects timing from the cycle after the applying wrap.
- mode, en, load and sync_clr are synchronous to CLOCK; no CDC inside the block.
- RESET mid-operation: outputs clear asynchronously and pending loads are lost.

## Structure
- Shared package clk_div_pkg: CNT_W default, N_CH_MAX=8, a divisor typedef, and the named standard divisors DIV_1KHZ_SQ=25_000, DIV_1HZ_SQ=25_000_000, DIV_2HZ_SQ=12_500_000, DIV_100HZ_SQ=250_000.
- Sub-module clk_div_chan: one channel (counter, pending logic, mode output).
- Top level: generate loop over N_CH plus load_ch decode.

## Test plan
- Override DIV_INIT={0,1,5,3}, all en=1, mode=0 → ch0 toggles every 3 cycles, ch1 every 5 cycles, ch2 and ch3 every cycle; wrap pulses coincide with each toggle.
- Set ch0 mode=1 with D=3 → clk_out[0] is high 1 of every 3 cycles and equals wrap[0]. Then en[0]=0 → clk_out[0]=0 and cnt holds.
- Load 7 to ch1 (running, D=5) at cnt=2 → 2 more cycles at period 5, then period 7. Load 4 then 6 before the wrap → period 6.
- sync_clr pulse with channels in random phases → next cycle every square clk_out=0 and cnt=0; wraps realign D cycles later.
- Load with load_ch=5 (N_CH=4) → no divisor changes. Load to disabled ch2 → applied at once, and the first wrap comes D cycles after en rises.
- RESET asserted mid-count, asynchronously between edges → clk_out=0 immediately; after release, divisors return to DIV_INIT and pending loads are gone.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants and types for the multi-channel clock divider.
// Standard divisors assume the 50 MHz board clock and square-wave mode.
package clk_div_pkg;

    localparam int unsigned DEF_CNT_W = 32;
    localparam int unsigned N_CH_MAX  = 8;

    typedef logic [DEF_CNT_W-1:0] div_t;

    typedef enum logic {
        MODE_SQUARE = 1'b0,
        MODE_TICK   = 1'b1
    } out_mode_e;

    localparam div_t DIV_1KHZ_SQ  = 32'd25_000;
    localparam div_t DIV_1HZ_SQ   = 32'd25_000_000;
    localparam div_t DIV_2HZ_SQ   = 32'd12_500_000;
    localparam div_t DIV_100HZ_SQ = 32'd250_000;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: wrap counter, glitch-free divisor reload and
// square/tick output shaping, all outputs registered.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned      CNT_W   = DEF_CNT_W,
    parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(1)
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [CNT_W-1:0] load_div,
    input  logic             sync_clr,
    output logic             clk_out,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] pdiv;
    logic [CNT_W-1:0] d_eff;
    logic             pend;
    logic             sq;
    logic             hit;

    always_comb begin
        d_eff = (div == '0) ? CNT_W'(1) : div;
        hit   = en && (cnt == d_eff - CNT_W'(1));
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            cnt     <= '0;
            div     <= DIV_RST;
            pdiv    <= '0;
            pend    <= 1'b0;
            sq      <= 1'b0;
            clk_out <= 1'b0;
            wrap    <= 1'b0;
        end else if (sync_clr) begin
            cnt     <= '0;
            sq      <= 1'b0;
            clk_out <= 1'b0;
            wrap    <= 1'b0;
            pend    <= 1'b0;
            if (load) begin
                div <= load_div;
            end else if (pend) begin
                div <= pdiv;
            end
        end else begin
            wrap <= hit;
            if (en) begin
                cnt <= hit ? '0 : cnt + CNT_W'(1);
            end

            // A running channel only ever switches divisor on a wrap edge,
            // so no shortened or stretched period can reach clk_out.
            if (load) begin
                if (!en) begin
                    div  <= load_div;
                    cnt  <= '0;
                    pend <= 1'b0;
                end else if (hit) begin
                    div  <= load_div;
                    pend <= 1'b0;
                end else begin
                    pdiv <= load_div;
                    pend <= 1'b1;
                end
            end else if (hit && pend) begin
                div  <= pdiv;
                pend <= 1'b0;
            end

            // The square level is frozen while the channel runs in tick mode.
            if (mode == MODE_TICK) begin
                clk_out <= hit;
            end else begin
                sq      <= sq ^ hit;
                clk_out <= sq ^ hit;
            end
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock divider: N_CH independent channels sharing one clock,
// a common reload port with channel decode and a global phase-align clear.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned               CLK_HZ   = 50_000_000,
    parameter int unsigned               CNT_W    = DEF_CNT_W,
    parameter int unsigned               N_CH     = 4,
    parameter logic [N_CH*CNT_W-1:0]     DIV_INIT = {DIV_1KHZ_SQ, DIV_1HZ_SQ,
                                                     DIV_2HZ_SQ, DIV_100HZ_SQ},
    localparam int unsigned              SEL_W    = sel_width(N_CH)
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [N_CH-1:0]  en,
    input  logic [N_CH-1:0]  mode,
    input  logic             load,
    input  logic [SEL_W-1:0] load_ch,
    input  logic [CNT_W-1:0] load_div,
    input  logic             sync_clr,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  wrap
);

    if (N_CH < 1 || N_CH > N_CH_MAX || CLK_HZ == 0) begin : g_bad_cfg
        $error("clk_div_multi: N_CH must be 1..%0d and CLK_HZ nonzero", N_CH_MAX);
    end

    logic load_ok;

    always_comb begin
        load_ok = load && (32'(load_ch) < N_CH);
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic sel;

        always_comb begin
            sel = load_ok && (load_ch == SEL_W'(i));
        end

        clk_div_chan #(
            .CNT_W   (CNT_W),
            .DIV_RST (DIV_INIT[i*CNT_W +: CNT_W])
        ) u_chan (
            .CLOCK    (CLOCK),
            .RESET    (RESET),
            .en       (en[i]),
            .mode     (mode[i]),
            .load     (sel),
            .load_div (load_div),
            .sync_clr (sync_clr),
            .clk_out  (clk_out[i]),
            .wrap     (wrap[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi with small divisors.
module tb_clk_div_multi;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic [3:0]  en;
    logic [3:0]  mode;
    logic        load;
    logic [1:0]  load_ch;
    logic [31:0] load_div;
    logic        sync_clr;
    logic [3:0]  clk_out;
    logic [3:0]  wrap;

    logic [2:0]  en3;
    logic [2:0]  mode3;
    logic        load3;
    logic [1:0]  load_ch3;
    logic [31:0] load_div3;
    logic        sync_clr3;
    logic [2:0]  clk_out3;
    logic [2:0]  wrap3;

    int checks = 0;
    int passed = 0;

    always #5 CLOCK = ~CLOCK;

    clk_div_multi #(
        .N_CH     (4),
        .DIV_INIT ({32'd0, 32'd1, 32'd5, 32'd3})
    ) u_dut (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .en       (en),
        .mode     (mode),
        .load     (load),
        .load_ch  (load_ch),
        .load_div (load_div),
        .sync_clr (sync_clr),
        .clk_out  (clk_out),
        .wrap     (wrap)
    );

    // Three-channel instance: select value 3 is out of range here.
    clk_div_multi #(
        .N_CH     (3),
        .DIV_INIT ({32'd2, 32'd2, 32'd2})
    ) u_dut3 (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .en       (en3),
        .mode     (mode3),
        .load     (load3),
        .load_ch  (load_ch3),
        .load_div (load_div3),
        .sync_clr (sync_clr3),
        .clk_out  (clk_out3),
        .wrap     (wrap3)
    );

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        step();
        step();
        checks++;
        if ({clk_out, wrap} !== 8'h00) $display("FAIL reset_main actual=%h required=00", {clk_out, wrap});
        else passed++;
        checks++;
        if ({clk_out3, wrap3} !== 6'h00) $display("FAIL reset_u3 actual=%h required=00", {clk_out3, wrap3});
        else passed++;
        RESET = 1'b0;
    endtask

    task automatic test_square();
        logic [3:0] ec, ew;
        en   = 4'hF;
        mode = 4'h0;
        for (int k = 1; k <= 15; k++) begin
            step();
            ec = {k % 2 == 1, k % 2 == 1, (k / 5) % 2 == 1, (k / 3) % 2 == 1};
            ew = {1'b1, 1'b1, k % 5 == 0, k % 3 == 0};
            checks++;
            if ({clk_out, wrap} !== {ec, ew})
                $display("FAIL square k=%0d actual=%b_%b required=%b_%b", k, clk_out, wrap, ec, ew);
            else passed++;
        end
    endtask

    task automatic test_tick();
        logic e;
        mode[0] = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            step();
            e = (j % 3 == 0);
            checks++;
            if ({clk_out[0], wrap[0]} !== {e, e})
                $display("FAIL tick j=%0d actual=%b%b required=%b%b", j, clk_out[0], wrap[0], e, e);
            else passed++;
        end
        en[0] = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            step();
            checks++;
            if ({clk_out[0], wrap[0]} !== 2'b00)
                $display("FAIL tick_disabled j=%0d actual=%b%b required=00", j, clk_out[0], wrap[0]);
            else passed++;
        end
        en[0] = 1'b1;
        step();
        checks++;
        if ({clk_out[0], wrap[0]} !== 2'b00)
            $display("FAIL tick_hold1 actual=%b%b required=00", clk_out[0], wrap[0]);
        else passed++;
        step();
        checks++;
        if ({clk_out[0], wrap[0]} !== 2'b11)
            $display("FAIL tick_hold2 actual=%b%b required=11", clk_out[0], wrap[0]);
        else passed++;
    endtask

    task automatic test_load();
        logic found;
        logic e;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            step();
            if (wrap[1]) found = 1'b1;
        end
        checks++;
        if (!found) $display("FAIL load_align wrap[1] actual=0 required=1 within 12 cycles");
        else passed++;
        step();
        step();
        load_ch = 2'd1;
        for (int k = 1; k <= 40; k++) begin
            case (k)
                1:       begin load = 1'b1; load_div = 32'd7; end
                18:      begin load = 1'b1; load_div = 32'd4; end
                19:      begin load = 1'b1; load_div = 32'd6; end
                36:      begin load = 1'b1; load_div = 32'd2; end
                default: load = 1'b0;
            endcase
            step();
            e = (k == 3 || k == 10 || k == 17 || k == 24 || k == 30 ||
                 k == 36 || k == 38 || k == 40);
            checks++;
            if (wrap[1] !== e) $display("FAIL load k=%0d wrap[1] actual=%b required=%b", k, wrap[1], e);
            else passed++;
        end
        load = 1'b0;
    endtask

    task automatic test_sync_clr();
        logic [3:0] ec, ew;
        mode = 4'h0;
        step();
        step();
        step();
        load     = 1'b1;
        load_ch  = 2'd0;
        load_div = 32'd4;
        step();
        load_ch  = 2'd1;
        load_div = 32'd3;
        sync_clr = 1'b1;
        step();
        checks++;
        if ({clk_out, wrap} !== 8'h00) $display("FAIL sync_clr actual=%b_%b required=0000_0000", clk_out, wrap);
        else passed++;
        load     = 1'b0;
        sync_clr = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            ec = {k % 2 == 1, k % 2 == 1, (k / 3) % 2 == 1, (k / 4) % 2 == 1};
            ew = {1'b1, 1'b1, k % 3 == 0, k % 4 == 0};
            checks++;
            if ({clk_out, wrap} !== {ec, ew})
                $display("FAIL sync_realign k=%0d actual=%b_%b required=%b_%b", k, clk_out, wrap, ec, ew);
            else passed++;
        end
    endtask

    task automatic test_disabled_load();
        en[2] = 1'b0;
        step();
        step();
        checks++;
        if ({clk_out[2], wrap[2]} !== 2'b00) $display("FAIL dis_hold actual=%b%b required=00", clk_out[2], wrap[2]);
        else passed++;
        load     = 1'b1;
        load_ch  = 2'd2;
        load_div = 32'd3;
        step();
        load = 1'b0;
        checks++;
        if ({clk_out[2], wrap[2]} !== 2'b00) $display("FAIL dis_load actual=%b%b required=00", clk_out[2], wrap[2]);
        else passed++;
        step();
        en[2] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++;
            if ({clk_out[2], wrap[2]} !== {(k / 3) % 2 == 1, k % 3 == 0})
                $display("FAIL dis_enable k=%0d actual=%b%b required=%b%b", k, clk_out[2], wrap[2],
                         (k / 3) % 2 == 1, k % 3 == 0);
            else passed++;
        end
    endtask

    task automatic test_range();
        logic [2:0] ew;
        sync_clr3 = 1'b1;
        step();
        sync_clr3 = 1'b0;
        checks++;
        if ({clk_out3, wrap3} !== 6'h00) $display("FAIL range_clr actual=%b_%b required=000_000", clk_out3, wrap3);
        else passed++;
        load3     = 1'b1;
        load_ch3  = 2'd3;
        load_div3 = 32'd1;
        for (int k = 1; k <= 6; k++) begin
            step();
            load3 = 1'b0;
            ew = (k % 2 == 0) ? 3'b111 : 3'b000;
            checks++;
            if (wrap3 !== ew) $display("FAIL range k=%0d wrap actual=%b required=%b", k, wrap3, ew);
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] ec, ew;
        load     = 1'b1;
        load_ch  = 2'd1;
        load_div = 32'd9;
        step();
        load = 1'b0;
        checks++;
        if (wrap[3] !== 1'b1) $display("FAIL pre_reset wrap[3] actual=%b required=1", wrap[3]);
        else passed++;
        #3;
        RESET = 1'b1;
        #1;
        checks++;
        if ({clk_out, wrap} !== 8'h00) $display("FAIL async_reset actual=%b_%b required=0000_0000", clk_out, wrap);
        else passed++;
        checks++;
        if ({clk_out3, wrap3} !== 6'h00) $display("FAIL async_reset_u3 actual=%b_%b required=000_000", clk_out3, wrap3);
        else passed++;
        step();
        RESET = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            step();
            ec = {k % 2 == 1, k % 2 == 1, (k / 5) % 2 == 1, (k / 3) % 2 == 1};
            ew = {1'b1, 1'b1, k % 5 == 0, k % 3 == 0};
            checks++;
            if ({clk_out, wrap} !== {ec, ew})
                $display("FAIL post_reset k=%0d actual=%b_%b required=%b_%b", k, clk_out, wrap, ec, ew);
            else passed++;
        end
    endtask

    initial begin
        RESET     = 1'b1;
        en        = 4'h0;
        mode      = 4'h0;
        load      = 1'b0;
        load_ch   = 2'd0;
        load_div  = 32'd0;
        sync_clr  = 1'b0;
        en3       = 3'b111;
        mode3     = 3'b000;
        load3     = 1'b0;
        load_ch3  = 2'd0;
        load_div3 = 32'd0;
        sync_clr3 = 1'b0;

        test_reset();
        test_square();
        test_tick();
        test_load();
        test_sync_clr();
        test_disabled_load();
        test_range();
        test_async_reset();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish passed=%0d checks=%0d", passed, checks);
        $fatal(1);
    end

endmodule
